// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: edge-detecting, maskable, fixed-priority interrupt controller with req/ack/done handshake
module interrupt_ctrl #(
    parameter int NUM_CH = 4,
    parameter int VEC_WIDTH = 16,
    parameter logic [VEC_WIDTH-1:0] BASE_VEC = '0,
    parameter int VEC_STRIDE = 2,
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    irqIn,
    input  logic                 maskWrEn,
    input  logic [NUM_CH-1:0]    maskWrData,
    input  logic                 intAck,
    input  logic                 intDone,
    output logic                 intReq,
    output logic [VEC_WIDTH-1:0] intVector,
    output logic [CW-1:0]        intChannel,
    output logic                 inService,
    output logic [NUM_CH-1:0]    pendingOut,
    output logic [NUM_CH-1:0]    maskOut
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t state;
    logic [NUM_CH-1:0] irq_prev, pending, mask, edge_det, eligible, clr;
    logic [CW-1:0] winner;
    logic [VEC_WIDTH-1:0] win_vec;
    assign pendingOut = pending;
    assign maskOut = mask;
    // Rising-edge detect, acknowledge clear, and lowest-index-wins arbitration
    always_comb begin
        edge_det = irqIn & ~irq_prev;
        eligible = pending & mask;
        clr = (state == REQ && intAck) ? NUM_CH'(1) << intChannel : '0;
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) winner = eligible[i] ? CW'(i) : winner;
        win_vec = BASE_VEC + VEC_WIDTH'(winner) * VEC_WIDTH'(VEC_STRIDE);
    end
    // Pending/mask registers and the handshake FSM; a new edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_prev <= '0;
            pending <= '0;
            mask <= '0;
            state <= IDLE;
            intReq <= 1'b0;
            intVector <= '0;
            intChannel <= '0;
            inService <= 1'b0;
        end else begin
            irq_prev <= irqIn;
            pending <= (pending & ~clr) | edge_det;
            if (maskWrEn) mask <= maskWrData;
            case (state)
                IDLE: if (|eligible) begin
                    state <= REQ;
                    intReq <= 1'b1;
                    intChannel <= winner;
                    intVector <= win_vec;
                end
                REQ: if (intAck) begin
                    state <= SERVICE;
                    intReq <= 1'b0;
                    inService <= 1'b1;
                end
                SERVICE: if (intDone) begin
                    state <= IDLE;
                    inService <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_ctrl.sv
// tb_interrupt_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_interrupt_ctrl;
    logic clk = 0, reset = 1, maskWrEn = 0, intAck = 0, intDone = 0;
    logic [3:0] irqIn = 0, maskWrData = 0;
    logic intReq, inService;
    logic [15:0] intVector;
    logic [1:0] intChannel;
    logic [3:0] pendingOut, maskOut;
    int checks = 0, fails = 0;

    bit [3:0] m_prev, m_pend, m_mask;
    bit m_req, m_svc;
    int m_ch;
    bit [15:0] m_vec;

    interrupt_ctrl #(.NUM_CH(4), .VEC_WIDTH(16), .BASE_VEC(16'h0010), .VEC_STRIDE(2)) dut (
        .clk(clk), .reset(reset), .irqIn(irqIn), .maskWrEn(maskWrEn), .maskWrData(maskWrData),
        .intAck(intAck), .intDone(intDone), .intReq(intReq), .intVector(intVector),
        .intChannel(intChannel), .inService(inService), .pendingOut(pendingOut), .maskOut(maskOut)
    );

    always #5 clk = ~clk;

    // Transaction-level view: one outstanding interrupt at a time, lowest enabled pending channel wins
    task automatic model_step();
        bit [3:0] e, clr;
        bit found;
        e = irqIn & ~m_prev;
        clr = 0;
        if (reset) begin
            m_prev = 0; m_pend = 0; m_mask = 0; m_req = 0; m_svc = 0; m_ch = 0; m_vec = 0;
            return;
        end
        if (m_req) begin
            if (intAck) begin clr[m_ch] = 1; m_req = 0; m_svc = 1; end
        end else if (m_svc) begin
            if (intDone) m_svc = 0;
        end else begin
            found = 0;
            for (int i = 0; i < 4; i++)
                if (!found && m_pend[i] && m_mask[i]) begin
                    found = 1; m_req = 1; m_ch = i; m_vec = 16'h0010 + 16'(2 * i);
                end
        end
        m_pend = (m_pend & ~clr) | e;
        m_prev = irqIn;
        if (maskWrEn) m_mask = maskWrData;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_done();
        intAck = 1; tick(); intAck = 0;
        intDone = 1; tick(); intDone = 0;
    endtask

    task automatic pulse(input logic [3:0] v);
        irqIn = v; tick(); irqIn = 0;
    endtask

    task automatic test_reset();
        reset = 1; irqIn = 4'hF;
        tick(); tick();
        checks++;
        if ({intReq, inService, intChannel, intVector, pendingOut, maskOut} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b svc=%b ch=%0d vec=%h pend=%h mask=%h, want all 0",
                     intReq, inService, intChannel, intVector, pendingOut, maskOut);
        end
        reset = 0;
        tick();
        checks++;
        if (pendingOut !== 4'hF) begin fails++; $display("FAIL reset_release_pending: got %h want f", pendingOut); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (intReq !== 1'b0) begin fails++; $display("FAIL masked_no_req: cycle %0d got %b want 0", i, intReq); end
        end
        irqIn = 0; reset = 1; tick(); reset = 0;
    endtask

    task automatic test_single();
        maskWrEn = 1; maskWrData = 4'hF; tick(); maskWrEn = 0;
        pulse(4'b0100);
        checks++;
        if (pendingOut !== 4'b0100 || intReq !== 1'b0) begin
            fails++; $display("FAIL single_pending: got pend=%b req=%b want 0100/0", pendingOut, intReq);
        end
        tick();
        checks++;
        if (intReq !== 1'b1 || intChannel !== 2'd2 || intVector !== 16'h0014) begin
            fails++; $display("FAIL single_req: got req=%b ch=%0d vec=%h want 1/2/0014", intReq, intChannel, intVector);
        end
        intAck = 1; tick(); intAck = 0;
        checks++;
        if (inService !== 1'b1 || intReq !== 1'b0 || pendingOut !== 4'b0000) begin
            fails++; $display("FAIL single_ack: got svc=%b req=%b pend=%b want 1/0/0000", inService, intReq, pendingOut);
        end
        intDone = 1; tick(); intDone = 0;
        checks++;
        if (inService !== 1'b0) begin fails++; $display("FAIL single_done: got svc=%b want 0", inService); end
    endtask

    task automatic test_priority();
        pulse(4'b1000);
        tick();
        checks++;
        if (intReq !== 1'b1 || intVector !== 16'h0016) begin
            fails++; $display("FAIL prio_first: got req=%b vec=%h want 1/0016", intReq, intVector);
        end
        pulse(4'b0001);
        tick();
        checks++;
        if (intVector !== 16'h0016 || intChannel !== 2'd3 || pendingOut !== 4'b1001) begin
            fails++; $display("FAIL prio_no_preempt: got vec=%h ch=%0d pend=%b want 0016/3/1001", intVector, intChannel, pendingOut);
        end
        ack_done();
        tick();
        checks++;
        if (intReq !== 1'b1 || intChannel !== 2'd0 || intVector !== 16'h0010) begin
            fails++; $display("FAIL prio_next: got req=%b ch=%0d vec=%h want 1/0/0010", intReq, intChannel, intVector);
        end
        ack_done();
    endtask

    task automatic test_mask();
        maskWrEn = 1; maskWrData = 4'b1110; tick(); maskWrEn = 0;
        pulse(4'b0001);
        tick();
        checks++;
        if (pendingOut !== 4'b0001 || intReq !== 1'b0) begin
            fails++; $display("FAIL mask_latch: got pend=%b req=%b want 0001/0", pendingOut, intReq);
        end
        maskWrEn = 1; maskWrData = 4'hF; tick(); maskWrEn = 0;
        checks++;
        if (intReq !== 1'b0 || maskOut !== 4'hF) begin
            fails++; $display("FAIL mask_write: got req=%b mask=%h want 0/f", intReq, maskOut);
        end
        tick();
        checks++;
        if (intReq !== 1'b1 || intVector !== 16'h0010) begin
            fails++; $display("FAIL mask_unmask_req: got req=%b vec=%h want 1/0010", intReq, intVector);
        end
        ack_done();
    endtask

    task automatic test_ack_edge();
        pulse(4'b0010);
        tick();
        checks++;
        if (intReq !== 1'b1 || intChannel !== 2'd1) begin
            fails++; $display("FAIL ackedge_req: got req=%b ch=%0d want 1/1", intReq, intChannel);
        end
        intAck = 1; irqIn = 4'b0010; tick(); intAck = 0; irqIn = 0;
        checks++;
        if (inService !== 1'b1 || pendingOut[1] !== 1'b1) begin
            fails++; $display("FAIL ackedge_set_wins: got svc=%b pend=%b want 1/x1x", inService, pendingOut);
        end
        intDone = 1; tick(); intDone = 0;
        tick();
        checks++;
        if (intReq !== 1'b1 || intChannel !== 2'd1 || intVector !== 16'h0012) begin
            fails++; $display("FAIL ackedge_rereq: got req=%b ch=%0d vec=%h want 1/1/0012", intReq, intChannel, intVector);
        end
        ack_done();
    endtask

    task automatic test_reset_mid();
        pulse(4'b0100);
        tick();
        intAck = 1; irqIn = 4'b1000; tick(); intAck = 0; irqIn = 0;
        checks++;
        if (inService !== 1'b1) begin fails++; $display("FAIL midreset_setup: got svc=%b want 1", inService); end
        reset = 1; tick(); reset = 0;
        checks++;
        if (inService !== 1'b0 || intReq !== 1'b0 || pendingOut !== 4'h0 || maskOut !== 4'h0) begin
            fails++; $display("FAIL midreset: got svc=%b req=%b pend=%h mask=%h want 0/0/0/0", inService, intReq, pendingOut, maskOut);
        end
    endtask

    task automatic test_random();
        reset = 1; tick(); reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) irqIn[i] = ~irqIn[i];
            maskWrEn = ($urandom_range(0, 15) == 0);
            maskWrData = 4'($urandom);
            intAck = ($urandom_range(0, 2) == 0);
            intDone = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (intReq !== m_req || inService !== m_svc || pendingOut !== m_pend || maskOut !== m_mask ||
                (m_req && (intChannel !== 2'(m_ch) || intVector !== m_vec))) begin
                fails++;
                $display("FAIL random cycle %0d: got req=%b svc=%b ch=%0d vec=%h pend=%b mask=%b want req=%b svc=%b ch=%0d vec=%h pend=%b mask=%b",
                         c, intReq, inService, intChannel, intVector, pendingOut, maskOut,
                         m_req, m_svc, m_ch, m_vec, m_pend, m_mask);
            end
        end
        reset = 0; maskWrEn = 0; intAck = 0; intDone = 0; irqIn = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_ack_edge();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Parametrised multi-channel interrupt controller in front of the processor core; supersedes the single `interruptSignal` input.
- Edge-detects up to NUM_CH external request lines and latches them as pending.
- Applies a software-writable mask and resolves fixed priority (channel 0 highest).
- Runs a request/acknowledge/done handshake with the core and presents a per-channel vector address.

Parameters:
NUM_CH, 4, number of interrupt request channels (1..16)
VEC_WIDTH, 16, width of vector address (matches core data/address width)
BASE_VEC, 16'h0000, vector address of channel 0
VEC_STRIDE, 2, address increment between consecutive channel vectors

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  synchronous active-high reset
irqIn  in  NUM_CH  raw interrupt request lines, rising-edge sensitive
maskWrEn  in  1  write strobe for mask register
maskWrData  in  NUM_CH  new mask value; bit=1 enables channel
intAck  in  1  core acknowledges current request (one-cycle pulse)
intDone  in  1  core finished ISR (RTI executed, one-cycle pulse)
intReq  out  1  interrupt request to core
intVector  out  VEC_WIDTH  vector address of the selected channel
intChannel  out  clog2(NUM_CH) (min 1)  index of the selected channel
inService  out  1  an ISR is in progress
pendingOut  out  NUM_CH  current pending register, for status reads
maskOut  out  NUM_CH  current mask register

Behaviour:
- Sampling: everything is sampled on rising clk edges.
- Reset state: all registers are zero when reset=1 at an edge:
  - irqPrev, pending and mask (mask=0 means all channels disabled).
  - state=IDLE, intReq=0, intVector=0, intChannel=0, inService=0.
- Reset mid-handshake: behaves identically to reset from power-up; the in-flight request is discarded and no ack is required.
- Edge detect: edge[i] = irqIn[i] & ~irqPrev[i]; irqPrev <= irqIn every cycle.
  - A line already high when reset releases produces an edge on the first cycle after reset.
- Pending update: pending[i] <= (pending[i] & ~clr[i]) | edge[i].
  - Set wins over clear: an edge arriving in the same cycle the channel is acked leaves it pending.
- Masking:
  - maskWrEn=1 loads maskWrData at the edge.
  - Mask gates only arbitration. Masked edges are still latched into pending and become eligible once unmasked.
- Arbitration: eligible = pending & mask; the lowest-index set bit wins.
- FSM has three states:
  - IDLE:
    - If eligible != 0: go to REQ.
    - Registered on the same edge: intReq=1, intChannel=winner, intVector = BASE_VEC + winner*VEC_STRIDE (truncated to VEC_WIDTH).
    - intAck in IDLE is ignored.
  - REQ:
    - intReq held at 1. intChannel and intVector are frozen; no preemption by a higher-priority channel.
    - A request that is masked after entry is still honoured.
    - intAck=1: go to SERVICE; intReq<=0, inService<=1, clr[intChannel]=1. Vector and channel stay held.
  - SERVICE:
    - No new request is raised (no nesting).
    - intDone=1: go to IDLE, inService<=0. Arbitration resumes the next cycle.
    - intAck in SERVICE is ignored.
  - intDone outside SERVICE is ignored.
- Latency:
  - irqIn rising, sampled at edge n → pending set after edge n → intReq=1 after edge n+1.
  - Minimum back-to-back gap: intDone at edge m → next intReq after edge m+1.
- Lost-edge rule: pending is one bit per channel. Multiple edges on a channel before its ack collapse into one service.
- Outputs: all outputs are registered or direct register copies; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: reset 2 cycles with irqIn=4'hF → all outputs 0. Release reset with mask=0 → pendingOut=4'hF and intReq stays 0 for 10 cycles.
- Single channel (BASE_VEC=16'h0010, STRIDE=2):
  - Setup: mask=4'hF, then pulse irqIn[2] at edge n.
  - pendingOut=4'b0100 after edge n; intReq=1, intChannel=2, intVector=16'h0014 after edge n+1.
  - Ack → inService=1, pendingOut=0. Done → inService=0.
- Priority, no preemption:
  - Raise irqIn[3]; once intReq=1 (vector 16'h0016), raise irqIn[0] → vector stays 16'h0016.
  - After ack+done, the next request is channel 0 with vector 16'h0010.
- Masking:
  - mask=4'b1110, pulse irqIn[0] → pending[0]=1 and no intReq.
  - Write mask=4'hF → intReq=1 with vector 16'h0010 two cycles later.
- Simultaneous ack and new edge: in REQ for ch1, a new irqIn[1] edge arrives in the same cycle as intAck → pending[1] remains 1. After intDone, ch1 is requested again.
- Reset mid-operation: assert reset while in SERVICE → next cycle inService=0, intReq=0, pendingOut=0, maskOut=0.
